// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register word indices and bus width.
// Latency: n/a (package only).
// Backpressure: n/a.
package gpio_pkg;

    localparam int GPIO_REGMAP_W = 32;
    localparam int GPIO_ADDR_W   = 4;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OE      = 4'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT     = 4'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_SET     = 4'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_CLR     = 4'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_TGL     = 4'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IN      = 4'd5;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_RISE_EN = 4'd6;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_FALL_EN = 4'd7;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_STATUS  = 4'd8;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [GPIO_REGMAP_W-1:0] gpio_byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_input_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, optional debounce, edge detect.
// Latency: pad change visible on o_in_q 2 edges later (plus debounce time when enabled).
// Backpressure: none; free-running every cycle.
//
// Optional feature macro: GPIO_DEBOUNCE_EN (adds a per-pin stability counter).
// Ports: i_clk, i_rst (sync, active-high), i_pin (async pad), i_rise_en/i_fall_en
//        (edge enables), o_in_q (filtered level), o_rise/o_fall (enabled edge events).
module gpio_input_filter
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_rise_en,
    input  logic i_fall_en,
    output logic o_in_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_in_prev;
    logic w_in_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The first cycle of a new value never counts (it differs from the previous
    // sample), so the update lands after DEBOUNCE_CYCLES-1 stable-and-different cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             r_sync_d;
    logic             r_in_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold;

    assign w_hold = (r_sync2 != r_in_q) && (r_sync2 == r_sync_d);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_d <= 1'b0;
            r_in_q   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync_d <= r_sync2;
            if (!w_hold) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_in_q <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_in_q = r_in_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign w_in_q = r_sync2;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_prev <= 1'b0;
        end else begin
            r_in_prev <= w_in_q;
        end
    end

    assign o_in_q = w_in_q;
    assign o_rise = w_in_q & ~r_in_prev & i_rise_en;
    assign o_fall = ~w_in_q & r_in_prev & i_fall_en;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: per-pin direction, atomic set/clear/toggle, filtered inputs, edge irqs.
// Latency: writes land at the bus_we edge; read data valid the cycle after bus_oe.
// Backpressure: bus_busy high only in the bus_oe cycle; writes never stall.
//
// Optional feature macro: GPIO_DEBOUNCE_EN (per-pin input debounce in gpio_input_filter).
// Ports: clk, rst (sync, active-high); bus_* peripheral bus (4-bit word address,
//        byte-enabled 32-bit writes, registered 32-bit reads); io_in (async pads),
//        io_out/io_oe (pad value/enable straight from OUT/OE); irq (level).
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [GPIO_ADDR_W-1:0]   bus_address,
    input  logic                     bus_we,
    input  logic                     bus_oe,
    input  logic [3:0]               bus_byteSelect,
    input  logic [GPIO_REGMAP_W-1:0] bus_dataWrite,
    output logic [GPIO_REGMAP_W-1:0] bus_dataRead,
    output logic                     bus_busy,
    input  logic [WIDTH-1:0]         io_in,
    output logic [WIDTH-1:0]         io_out,
    output logic [WIDTH-1:0]         io_oe,
    output logic                     irq
);

    logic [WIDTH-1:0]         r_oe;
    logic [WIDTH-1:0]         r_out;
    logic [WIDTH-1:0]         r_rise_en;
    logic [WIDTH-1:0]         r_fall_en;
    logic [WIDTH-1:0]         r_status;
    logic                     r_irq;
    logic [GPIO_REGMAP_W-1:0] r_rdata;

    logic [GPIO_REGMAP_W-1:0] w_mask32;
    logic [GPIO_REGMAP_W-1:0] w_wd32;
    logic [WIDTH-1:0]         w_mask;
    logic [WIDTH-1:0]         w_wd;
    logic [WIDTH-1:0]         w_w1c;
    logic [WIDTH-1:0]         w_in_q;
    logic [WIDTH-1:0]         w_rise;
    logic [WIDTH-1:0]         w_fall;
    logic [WIDTH-1:0]         w_rd_pin;
    logic [GPIO_REGMAP_W-1:0] w_rdata;
    logic                     w_rd;

    // Masked-off bytes become zero data, which is a no-op for SET/CLR/TGL/STATUS.
    assign w_mask32 = gpio_byte_mask(bus_byteSelect);
    assign w_wd32   = bus_dataWrite & w_mask32;
    assign w_mask   = w_mask32[WIDTH-1:0];
    assign w_wd     = w_wd32[WIDTH-1:0];

    generate
        if (WIDTH < GPIO_REGMAP_W) begin : g_hi_bits
            logic w_unused_hi;
            assign w_unused_hi = ^{w_mask32[GPIO_REGMAP_W-1:WIDTH], w_wd32[GPIO_REGMAP_W-1:WIDTH]};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            gpio_input_filter #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_filter (
                .i_clk    (clk),
                .i_rst    (rst),
                .i_pin    (io_in[gi]),
                .i_rise_en(r_rise_en[gi]),
                .i_fall_en(r_fall_en[gi]),
                .o_in_q   (w_in_q[gi]),
                .o_rise   (w_rise[gi]),
                .o_fall   (w_fall[gi])
            );
        end
    endgenerate

    // A simultaneous write wins over the read.
    assign w_rd  = bus_oe && !bus_we;
    assign w_w1c = (bus_we && (bus_address == GPIO_REG_STATUS)) ? w_wd : '0;

    always_comb begin
        w_rd_pin = '0;
        case (bus_address)
            GPIO_REG_OE:      w_rd_pin = r_oe;
            GPIO_REG_OUT:     w_rd_pin = r_out;
            GPIO_REG_IN:      w_rd_pin = w_in_q;
            GPIO_REG_RISE_EN: w_rd_pin = r_rise_en;
            GPIO_REG_FALL_EN: w_rd_pin = r_fall_en;
            GPIO_REG_STATUS:  w_rd_pin = r_status;
            default:          w_rd_pin = '0;
        endcase
        w_rdata              = '0;
        w_rdata[WIDTH-1:0]   = w_rd_pin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe      <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (bus_we) begin
                case (bus_address)
                    GPIO_REG_OE:      r_oe      <= (r_oe & ~w_mask) | w_wd;
                    GPIO_REG_OUT:     r_out     <= (r_out & ~w_mask) | w_wd;
                    GPIO_REG_SET:     r_out     <= r_out | w_wd;
                    GPIO_REG_CLR:     r_out     <= r_out & ~w_wd;
                    GPIO_REG_TGL:     r_out     <= r_out ^ w_wd;
                    GPIO_REG_RISE_EN: r_rise_en <= (r_rise_en & ~w_mask) | w_wd;
                    GPIO_REG_FALL_EN: r_fall_en <= (r_fall_en & ~w_mask) | w_wd;
                    default: ;
                endcase
            end
            // New events are OR-ed after the clear so they survive a same-cycle W1C.
            r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
            r_irq    <= |r_status;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign io_out       = r_out;
    assign io_oe        = r_oe;
    assign irq          = r_irq;
    assign bus_busy     = w_rd && !rst;
    // Reset aborts any read in flight, so nothing is presented while it is asserted.
    assign bus_dataRead = rst ? '0 : r_rdata;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus randomized bus/pin traffic
// compared each cycle against a register-map level reference model.
// Optional feature macro: GPIO_DEBOUNCE_EN (model and directed pulse test follow it).
module tb_gpio_bank;

    localparam int W  = 16;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    bus_address;
    logic          bus_we;
    logic          bus_oe;
    logic [3:0]    bus_byteSelect;
    logic [31:0]   bus_dataWrite;
    logic [31:0]   bus_dataRead;
    logic          bus_busy;
    logic [W-1:0]  io_in;
    logic [W-1:0]  io_out;
    logic [W-1:0]  io_oe;
    logic          irq;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_address   (bus_address),
        .bus_we        (bus_we),
        .bus_oe        (bus_oe),
        .bus_byteSelect(bus_byteSelect),
        .bus_dataWrite (bus_dataWrite),
        .bus_dataRead  (bus_dataRead),
        .bus_busy      (bus_busy),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_oe         (io_oe),
        .irq           (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: register map contents plus pad history as seen through
    // the two synchroniser stages (p_a = one edge old, p_b = two edges old).
    logic [W-1:0]  m_oe, m_out, m_re, m_fe, m_st, m_prev;
    logic          m_irq;
    logic [31:0]   m_rd;
    logic [W-1:0]  p_a, p_b;
    logic [W-1:0]  cur_pins;
`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0]  m_inq;
    logic [W-1:0]  wnd [DC];
`endif

    task automatic model_edge(input logic r, input logic we, input logic oe,
                              input logic [3:0] a, input logic [3:0] be,
                              input logic [31:0] d, input logic [W-1:0] pins);
        logic [W-1:0] mask, dm, inq, ev, w1c;
        if (r) begin
            m_oe = '0; m_out = '0; m_re = '0; m_fe = '0; m_st = '0; m_prev = '0;
            m_irq = 1'b0; m_rd = '0; p_a = '0; p_b = '0;
`ifdef GPIO_DEBOUNCE_EN
            m_inq = '0;
            for (int i = 0; i < DC; i++) wnd[i] = '0;
`endif
            return;
        end
        mask = '0;
        for (int b = 0; b < W; b++) mask[b] = be[b/8];
        dm = d[W-1:0] & mask;
`ifdef GPIO_DEBOUNCE_EN
        inq = m_inq;
`else
        inq = p_b;
`endif
        ev  = (inq & ~m_prev & m_re) | (~inq & m_prev & m_fe);
        w1c = (we && a == 4'd8) ? dm : '0;
        if (oe && !we) begin
            case (a)
                4'd0:    m_rd = 32'(m_oe);
                4'd1:    m_rd = 32'(m_out);
                4'd5:    m_rd = 32'(inq);
                4'd6:    m_rd = 32'(m_re);
                4'd7:    m_rd = 32'(m_fe);
                4'd8:    m_rd = 32'(m_st);
                default: m_rd = '0;
            endcase
        end
        m_irq = |m_st;
        m_st  = (m_st & ~w1c) | ev;
        if (we) begin
            case (a)
                4'd0: m_oe  = (m_oe & ~mask) | dm;
                4'd1: m_out = (m_out & ~mask) | dm;
                4'd2: m_out = m_out | dm;
                4'd3: m_out = m_out & ~dm;
                4'd4: m_out = m_out ^ dm;
                4'd6: m_re  = (m_re & ~mask) | dm;
                4'd7: m_fe  = (m_fe & ~mask) | dm;
                default: ;
            endcase
        end
        m_prev = inq;
`ifdef GPIO_DEBOUNCE_EN
        begin
            logic [W-1:0] all1, all0;
            // Filtered level follows the synchronised pin once it has held for DC cycles.
            for (int i = DC - 1; i > 0; i--) wnd[i] = wnd[i-1];
            wnd[0] = p_b;
            all1 = '1; all0 = '1;
            for (int i = 0; i < DC; i++) begin
                all1 &= wnd[i];
                all0 &= ~wnd[i];
            end
            m_inq = (m_inq | all1) & ~all0;
        end
`endif
        p_b = p_a;
        p_a = pins;
    endtask

    // One bus cycle: drive, check outputs mid-cycle, advance model, cross the edge.
    task automatic step(input logic r, input logic we, input logic oe,
                        input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        rst = r; bus_we = we; bus_oe = oe; bus_address = a;
        bus_byteSelect = be; bus_dataWrite = d; io_in = cur_pins;
        #3;
        check("busy",   32'(bus_busy), 32'(oe & ~we & ~r));
        check("io_out", 32'(io_out),   32'(m_out));
        check("io_oe",  32'(io_oe),    32'(m_oe));
        check("irq",    32'(irq),      32'(m_irq));
        check("rdata",  bus_dataRead,  r ? 32'd0 : m_rd);
        model_edge(r, we, oe, a, be, d, cur_pins);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                                   step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0); endtask
    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d); step(1'b0, 1'b1, 1'b0, a, be, d); endtask
    task automatic rd(input logic [3:0] a);                 step(1'b0, 1'b0, 1'b1, a, 4'd0, 32'd0); endtask

    initial begin
        cur_pins = '0;
        rst = 1'b1; bus_we = 1'b0; bus_oe = 1'b0; bus_address = '0;
        bus_byteSelect = '0; bus_dataWrite = '0; io_in = '0;
        model_edge(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);

        // Reset state: every index reads zero, pads undriven, no interrupt.
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            check($sformatf("reset_rd%0d", a), bus_dataRead, 32'd0);
        end
        check("reset_io_oe", 32'(io_oe), 32'd0);
        check("reset_irq",   32'(irq),   32'd0);

        // Atomic output operations and byte-enabled write.
        wr(4'd0, 4'hF, 32'h0000_FFFF);
        wr(4'd1, 4'hF, 32'h0000_00F0);
        wr(4'd2, 4'hF, 32'h0000_000F);
        wr(4'd3, 4'hF, 32'h0000_0030);
        wr(4'd4, 4'hF, 32'h0000_FF00);
        check("set_clr_tgl", 32'(io_out), 32'h0000_FFCF);
        wr(4'd1, 4'b0001, 32'h0000_1234);
        check("byte_sel_out", 32'(io_out), 32'h0000_FF34);
        rd(4'd0);
        check("oe_readback", bus_dataRead, 32'h0000_FFFF);

        // Input sampling latency.
        cur_pins = 16'h0005;
`ifdef GPIO_DEBOUNCE_EN
        repeat (10) idle();
        rd(4'd5);
        check("in_settled", bus_dataRead, 32'h0000_0005);
`else
        idle();
        rd(4'd5);
        check("in_2nd_edge", bus_dataRead, 32'h0000_0000);
        rd(4'd5);
        check("in_3rd_edge", bus_dataRead, 32'h0000_0005);
`endif

        // Rise on pin0, fall on pin1, then W1C of pin0.
        cur_pins = 16'h0002;
        repeat (10) idle();
        wr(4'd6, 4'hF, 32'h0000_0001);
        wr(4'd7, 4'hF, 32'h0000_0002);
        cur_pins = 16'h0001;
        repeat (10) idle();
        rd(4'd8);
        check("status_edges", bus_dataRead, 32'h0000_0003);
        check("irq_set", 32'(irq), 32'd1);
        wr(4'd8, 4'hF, 32'h0000_0001);
        rd(4'd8);
        check("status_w1c", bus_dataRead, 32'h0000_0002);

`ifndef GPIO_DEBOUNCE_EN
        // W1C on pin1 in the same cycle as a fresh pin1 fall: the event wins.
        wr(4'd8, 4'hF, 32'h0000_0003);
        cur_pins = 16'h0003;
        repeat (6) idle();
        cur_pins = 16'h0001;
        idle();
        idle();
        wr(4'd8, 4'hF, 32'h0000_0002);
        rd(4'd8);
        check("w1c_collision", bus_dataRead, 32'h0000_0002);
        wr(4'd8, 4'hF, 32'h0000_0002);
        rd(4'd8);
        check("w1c_after", bus_dataRead, 32'h0000_0000);
`else
        // Short pulse is filtered out; a long one passes and raises an event.
        cur_pins = 16'h0000;
        repeat (10) idle();
        wr(4'd8, 4'hF, 32'h0000_FFFF);
        cur_pins = 16'h0001;
        repeat (DC - 1) idle();
        cur_pins = 16'h0000;
        repeat (10) idle();
        rd(4'd5);
        check("deb_short_in", bus_dataRead, 32'h0000_0000);
        rd(4'd8);
        check("deb_short_status", bus_dataRead, 32'h0000_0000);
        cur_pins = 16'h0001;
        repeat (DC + 2) idle();
        repeat (4) idle();
        rd(4'd5);
        check("deb_long_in", bus_dataRead, 32'h0000_0001);
        rd(4'd8);
        check("deb_long_status", bus_dataRead, 32'h0000_0001);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic        r, we, oe;
            logic [3:0]  a, be;
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) cur_pins = W'($urandom);
            r  = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 2) == 0);
            oe = ($urandom_range(0, 2) == 0);
            a  = 4'($urandom_range(0, 15));
            be = 4'($urandom);
            d  = $urandom;
            step(r, we, oe, a, be, d);
        end

        // Reset in the cycle after a read aborts it and clears everything.
        wr(4'd0, 4'hF, 32'h0000_ABCD);
        wr(4'd6, 4'hF, 32'h0000_00FF);
        rd(4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("abort_busy",  32'(bus_busy), 32'd0);
        check("abort_rdata", bus_dataRead,  32'd0);
        check("abort_io_oe", 32'(io_oe),    32'd0);
        for (int a = 0; a < 9; a++) begin
            rd(4'(a));
            check($sformatf("abort_reg%0d", a), bus_dataRead, (a == 5) ? 32'(p_b) : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
